power_switch_seq: RTL and testbench

//  Consumes PMC per-domain power requests (PF,PD,PM,PA,PS) and sequences the physical header switches
//  and output isolation of the five gated domains (FFT, DLX, DMEM, AES, SPI).

---
 rtl/power_switch_seq.sv | 165 ++++++++++++++++
 tb/tb_power_switch_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_switch_seq.sv
// Power-switch sequencer: one-at-a-time header ramp, isolation and power-good for five domains.
// Define RETENTION_EN to add the SAVE state and the ret_save/ret_rest pulses.
module power_switch_seq #(
  parameter int RAMP_CYC = 16,
  parameter int ISO_CYC  = 2,
  parameter int OFF_HOLD = 8
) (
  input  logic       clk,
  input  logic       resn,
  input  logic [4:0] pwr_req,
  output logic [4:0] sw_en,
  output logic [4:0] iso_n,
  output logic [4:0] pwr_ok,
  output logic       ramp_busy,
  output logic [4:0] ret_save,
  output logic [4:0] ret_rest
);

  localparam int N = 5;

  localparam logic [7:0] LP_RAMP_M1 = 8'(RAMP_CYC - 1);
  localparam logic [7:0] LP_ISO_M1  = 8'(ISO_CYC - 1);
  localparam logic [7:0] LP_HOLD    = 8'(OFF_HOLD);

  typedef enum logic [2:0] {
    S_OFF,
    S_WAIT,
    S_RAMP,
    S_DEISO,
    S_ON,
    S_ISO,
    S_SAVE
  } state_t;

  logic [N-1:0] r_req;
  state_t       r_st    [N];
  state_t       w_nst   [N];
  logic [7:0]   r_cnt   [N];
  logic [7:0]   w_ncnt  [N];
  logic [7:0]   r_hold  [N];
  logic [7:0]   w_nhold [N];

  logic [N-1:0] w_cand;
  logic [N-1:0] w_inramp;
  logic [N-1:0] w_grant;
  logic         w_any_ramp;

  always_comb begin
    w_cand   = '0;
    w_inramp = '0;
    for (int i = 0; i < N; i++) begin
      w_inramp[i] = (r_st[i] == S_RAMP);
      w_cand[i]   = r_req[i] &&
                    ((r_st[i] == S_OFF && r_hold[i] >= LP_HOLD) ||
                     r_st[i] == S_WAIT);
    end
  end

  // Single ramp slot; lowest requesting bit wins.
  assign w_any_ramp = |w_inramp;
  assign w_grant    = w_any_ramp ? '0 : (w_cand & (~w_cand + 5'd1));

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_nst[i]   = r_st[i];
      w_ncnt[i]  = '0;
      w_nhold[i] = r_hold[i];
      if ((r_st[i] == S_OFF || r_st[i] == S_WAIT) &&
          r_hold[i] != 8'hFF)
        w_nhold[i] = r_hold[i] + 8'd1;
      case (r_st[i])
        S_OFF: begin
          if (w_cand[i])
            w_nst[i] = w_grant[i] ? S_RAMP : S_WAIT;
        end
        S_WAIT: begin
          if (!r_req[i])
            w_nst[i] = S_OFF;
          else if (w_grant[i])
            w_nst[i] = S_RAMP;
        end
        S_RAMP: begin
          if (!r_req[i]) begin
            w_nst[i]   = S_OFF;
            w_nhold[i] = '0;
          end else if (r_cnt[i] == LP_RAMP_M1) begin
            w_nst[i] = S_DEISO;
          end else begin
            w_ncnt[i] = r_cnt[i] + 8'd1;
          end
        end
        S_DEISO: begin
          if (!r_req[i])
            w_nst[i] = S_ISO;
          else if (r_cnt[i] == LP_ISO_M1)
            w_nst[i] = S_ON;
          else
            w_ncnt[i] = r_cnt[i] + 8'd1;
        end
        S_ON: begin
          if (!r_req[i])
            w_nst[i] = S_ISO;
        end
        S_ISO: begin
          if (r_cnt[i] == LP_ISO_M1) begin
`ifdef RETENTION_EN
            w_nst[i] = S_SAVE;
`else
            w_nst[i]   = S_OFF;
            w_nhold[i] = '0;
`endif
          end else begin
            w_ncnt[i] = r_cnt[i] + 8'd1;
          end
        end
        S_SAVE: begin
          w_nst[i]   = S_OFF;
          w_nhold[i] = '0;
        end
        default: begin
          w_nst[i] = S_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resn) begin
      r_req <= '0;
      for (int i = 0; i < N; i++) begin
        r_st[i]   <= S_OFF;
        r_cnt[i]  <= '0;
        r_hold[i] <= 8'hFF;
      end
    end else begin
      r_req <= pwr_req;
      for (int i = 0; i < N; i++) begin
        r_st[i]   <= w_nst[i];
        r_cnt[i]  <= w_ncnt[i];
        r_hold[i] <= w_nhold[i];
      end
    end
  end

  always_comb begin
    sw_en    = '0;
    iso_n    = '0;
    pwr_ok   = '0;
    ret_save = '0;
    ret_rest = '0;
    for (int i = 0; i < N; i++) begin
      sw_en[i]  = (r_st[i] != S_OFF) && (r_st[i] != S_WAIT);
      iso_n[i]  = (r_st[i] == S_ON);
      pwr_ok[i] = (r_st[i] == S_ON);
`ifdef RETENTION_EN
      ret_save[i] = (r_st[i] == S_SAVE);
      ret_rest[i] = (r_st[i] == S_DEISO) && (r_cnt[i] == 8'd0);
`endif
    end
  end

  // Slot counts as taken while a grant is being issued as well.
  assign ramp_busy = w_any_ramp | (|w_grant);

endmodule

// File: tb/tb_power_switch_seq.sv
// Bench for power_switch_seq: timestamp-based domain model plus directed scenarios.
// Honours RETENTION_EN the same way as the design.
module tb_power_switch_seq;

  localparam int RAMP_CYC = 16;
  localparam int ISO_CYC  = 2;
  localparam int OFF_HOLD = 8;
`ifdef RETENTION_EN
  localparam int RETX = 1;
`else
  localparam int RETX = 0;
`endif

  localparam int P_OFF   = 0;
  localparam int P_RAMP  = 1;
  localparam int P_DEISO = 2;
  localparam int P_ON    = 3;
  localparam int P_ISO   = 4;
  localparam int P_SAVE  = 5;

  logic       clk;
  logic       resn;
  logic [4:0] pwr_req;
  logic [4:0] sw_en;
  logic [4:0] iso_n;
  logic [4:0] pwr_ok;
  logic       ramp_busy;
  logic [4:0] ret_save;
  logic [4:0] ret_rest;

  power_switch_seq #(
    .RAMP_CYC(RAMP_CYC),
    .ISO_CYC (ISO_CYC),
    .OFF_HOLD(OFF_HOLD)
  ) dut (
    .clk      (clk),
    .resn     (resn),
    .pwr_req  (pwr_req),
    .sw_en    (sw_en),
    .iso_n    (iso_n),
    .pwr_ok   (pwr_ok),
    .ramp_busy(ramp_busy),
    .ret_save (ret_save),
    .ret_rest (ret_rest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Model: each domain is described by the cycle it started ramping,
  // the cycle it started powering down and the cycle it last entered OFF.
  int         cyc = 0;
  int         ramp_at [5];
  int         down_at [5];
  int         off_at  [5];
  logic [4:0] prev_req = '0;
  bit         mvalid = 0;

  function automatic int phase(int d, int c);
    int e;
    if (down_at[d] >= 0) begin
      e = c - down_at[d];
      if (e < ISO_CYC) return P_ISO;
      return P_SAVE;
    end
    if (ramp_at[d] >= 0) begin
      e = c - ramp_at[d];
      if (e < RAMP_CYC) return P_RAMP;
      if (e < RAMP_CYC + ISO_CYC) return P_DEISO;
      return P_ON;
    end
    return P_OFF;
  endfunction

  function automatic bit elig(int d, int c, logic [4:0] rq);
    return ramp_at[d] < 0 && down_at[d] < 0 && rq[d] &&
           (c - off_at[d] >= OFF_HOLD);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!resn) begin
      for (int d = 0; d < 5; d++) begin
        ramp_at[d] = -1;
        down_at[d] = -1;
        off_at[d]  = -1000;
      end
      prev_req = '0;
      mvalid   = 1;
    end else if (mvalid) begin
      automatic bit         busy_p = 0;
      automatic int         g = -1;
      automatic logic [4:0] rq = prev_req;
      for (int d = 0; d < 5; d++)
        if (phase(d, cyc - 1) == P_RAMP) busy_p = 1;
      if (!busy_p)
        for (int d = 0; d < 5; d++)
          if (g < 0 && elig(d, cyc - 1, rq)) g = d;
      for (int d = 0; d < 5; d++) begin
        automatic int p = phase(d, cyc - 1);
        if (down_at[d] >= 0) begin
          if (cyc - down_at[d] == ISO_CYC + RETX) begin
            down_at[d] = -1;
            off_at[d]  = cyc;
          end
        end else if (ramp_at[d] >= 0) begin
          if (!rq[d]) begin
            ramp_at[d] = -1;
            if (p == P_RAMP) off_at[d] = cyc;
            else down_at[d] = cyc;
          end
        end else if (d == g) begin
          ramp_at[d] = cyc;
        end
      end
      prev_req = pwr_req;
    end
  end

  initial forever begin
    @(negedge clk);
    if (mvalid) begin
      automatic logic [4:0] e_sw = '0;
      automatic logic [4:0] e_iso = '0;
      automatic logic [4:0] e_sv = '0;
      automatic logic [4:0] e_rs = '0;
      automatic logic       e_bz = 1'b0;
      for (int d = 0; d < 5; d++) begin
        automatic int p = phase(d, cyc);
        e_sw[d]  = (p != P_OFF);
        e_iso[d] = (p == P_ON);
        e_sv[d]  = (p == P_SAVE);
        e_rs[d]  = (RETX == 1) && (p == P_DEISO) &&
                   (cyc - ramp_at[d] == RAMP_CYC);
        if (p == P_RAMP || elig(d, cyc, prev_req)) e_bz = 1'b1;
      end
      chk("m_sw_en", {3'b0, sw_en}, {3'b0, e_sw});
      chk("m_iso_n", {3'b0, iso_n}, {3'b0, e_iso});
      chk("m_pwr_ok", {3'b0, pwr_ok}, {3'b0, e_iso});
      chk("m_busy", {7'b0, ramp_busy}, {7'b0, e_bz});
      chk("m_ret_save", {3'b0, ret_save}, {3'b0, e_sv});
      chk("m_ret_rest", {3'b0, ret_rest}, {3'b0, e_rs});
    end
  end

  initial begin
    int gaps;
    int ok3;
    resn    = 1'b0;
    pwr_req = 5'h1F;
    repeat (3) @(negedge clk);
    chk("rst_sw", {3'b0, sw_en}, 8'h00);
    chk("rst_iso", {3'b0, iso_n}, 8'h00);
    chk("rst_ok", {3'b0, pwr_ok}, 8'h00);
    chk("rst_busy", {7'b0, ramp_busy}, 8'h00);

    // Release with everything requested: strict ordered ramp.
    resn = 1'b1;
    gaps = 0;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      if (k <= 85 && ramp_busy !== 1'b1) gaps++;
      if (k == 1)  chk("t1_sw_e0", {3'b0, sw_en}, 8'h00);
      if (k == 2)  chk("t1_sw_e1", {3'b0, sw_en}, 8'h01);
      if (k == 19) chk("t1_ok_e18", {3'b0, pwr_ok}, 8'h00);
      if (k == 19) chk("t2_sw_e18", {3'b0, sw_en}, 8'h03);
      if (k == 20) chk("t1_ok_e19", {3'b0, pwr_ok}, 8'h01);
      if (k == 35) chk("t2_sw_e34", {3'b0, sw_en}, 8'h03);
      if (k == 36) chk("t2_sw_e35", {3'b0, sw_en}, 8'h07);
      if (k == 70) chk("t2_sw_e69", {3'b0, sw_en}, 8'h1F);
      if (k == 86) chk("t2_busy_end", {7'b0, ramp_busy}, 8'h00);
      if (k == 87) chk("t2_ok_e86", {3'b0, pwr_ok}, 8'h0F);
      if (k == 88) chk("t2_ok_e87", {3'b0, pwr_ok}, 8'h1F);
    end
    chk("t2_busy_gaps", 8'(gaps), 8'h00);

    // Power-down of PD and early re-request held off by OFF_HOLD.
    pwr_req = 5'h1D;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 1)  chk("t3_iso_t", {3'b0, iso_n}, 8'h1F);
      if (k == 2)  chk("t3_iso_t1", {3'b0, iso_n}, 8'h1D);
      if (k == 2)  chk("t3_ok_t1", {3'b0, pwr_ok}, 8'h1D);
      if (k == 3)  chk("t3_sw_t2", {3'b0, sw_en}, 8'h1F);
      if (k == 4)  chk("t3_sw_t3", {3'b0, sw_en}, 8'h1D);
      if (k == 4)  pwr_req = 5'h1F;
      if (k == 12) chk("t3_sw_hold", {3'b0, sw_en}, 8'h1D);
      if (k == 13) chk("t3_sw_reramp", {3'b0, sw_en}, 8'h1F);
      if (k == 30) chk("t3_ok_t29", {3'b0, pwr_ok}, 8'h1D);
      if (k == 31) chk("t3_ok_t30", {3'b0, pwr_ok}, 8'h1F);
    end

    // Everything down, then PA aborts mid-ramp while PS waits.
    pwr_req = 5'h00;
    repeat (15) @(negedge clk);
    chk("t4_all_off", {3'b0, sw_en}, 8'h00);
    pwr_req = 5'h08;
    ok3 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (pwr_ok[3] !== 1'b0) ok3++;
      if (k == 1) chk("t4_sw_s", {3'b0, sw_en}, 8'h00);
      if (k == 2) chk("t4_sw_s1", {3'b0, sw_en}, 8'h08);
      if (k == 6) pwr_req = 5'h10;
      if (k == 7) chk("t4_sw_s6", {3'b0, sw_en}, 8'h08);
      if (k == 8) chk("t4_sw_abort", {3'b0, sw_en}, 8'h00);
      if (k == 9) chk("t4_sw_next", {3'b0, sw_en}, 8'h10);
    end
    chk("t4_pa_never_ok", 8'(ok3), 8'h00);

    // Reset while PS is ramping.
    resn = 1'b0;
    @(negedge clk);
    chk("t5_sw", {3'b0, sw_en}, 8'h00);
    chk("t5_busy", {7'b0, ramp_busy}, 8'h00);
    chk("t5_save", {3'b0, ret_save}, 8'h00);
    resn    = 1'b1;
    pwr_req = 5'h00;
    repeat (3) @(negedge clk);
    chk("t5_sw_after", {3'b0, sw_en}, 8'h00);

    // PM up, down (retention save when enabled), up again.
    pwr_req = 5'h04;
    repeat (25) @(negedge clk);
    chk("t6_ok_up", {3'b0, pwr_ok}, 8'h04);
    pwr_req = 5'h00;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 3) chk("t6_sw_t2", {3'b0, sw_en}, 8'h04);
      if (k == 3) chk("t6_save_t2", {3'b0, ret_save}, 8'h00);
      if (k == 4) chk("t6_save_t3", {3'b0, ret_save},
                      (RETX == 1) ? 8'h04 : 8'h00);
      if (k == 4) chk("t6_sw_t3", {3'b0, sw_en},
                      (RETX == 1) ? 8'h04 : 8'h00);
      if (k == 5) chk("t6_sw_t4", {3'b0, sw_en}, 8'h00);
    end
    repeat (12) @(negedge clk);
    pwr_req = 5'h04;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 18) chk("t6_rest", {3'b0, ret_rest},
                       (RETX == 1) ? 8'h04 : 8'h00);
      if (k == 18) chk("t6_iso_deiso", {3'b0, iso_n}, 8'h00);
      if (k == 19) chk("t6_rest_end", {3'b0, ret_rest}, 8'h00);
      if (k == 20) chk("t6_iso_on", {3'b0, iso_n}, 8'h04);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
